// File: rtl/plpbot_uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO: drain FSM encodings, default depth,
// and bus-wrapper command/status bit positions.
package plpbot_uart_tx_fifo_pkg;

    typedef enum logic [1:0] {
        TXF_IDLE = 2'd0,
        TXF_LOAD = 2'd1,
        TXF_BUSY = 2'd2,
        TXF_DONE = 2'd3
    } txf_state_t;

    localparam int TXF_DEPTH_DEF  = 16;
    localparam int TXF_ADDR_W_DEF = 4;

    // Status register bits seen by software through the bus wrapper
    localparam int TXF_STAT_EMPTY_BIT = 0;
    localparam int TXF_STAT_FULL_BIT  = 1;
    localparam int TXF_STAT_OVF_BIT   = 2;
    localparam int TXF_STAT_BUSY_BIT  = 3;

    // Command register bits
    localparam int TXF_CMD_FLUSH_BIT  = 0;

endpackage

// File: rtl/plpbot_uart_fifo_ram.sv
// DEPTH x 8 byte storage for the UART transmit FIFO: one falling-edge write port,
// asynchronous read port.
module plpbot_uart_fifo_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(negedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/plpbot_uart_tx_fifo.sv
// Transmit byte FIFO feeding plpbot_uart_core: bus pushes, drain FSM pops on cts and pulses send.
// Optional occupancy counter enabled by defining PLPBOT_UART_TXF_LEVEL_EN.
module plpbot_uart_tx_fifo
    import plpbot_uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH  = TXF_DEPTH_DEF,
    parameter int ADDR_W = TXF_ADDR_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [7:0]      wr_data,
    input  logic            flush,
    output logic            full,
    output logic            empty,
    output logic            overflow,
    output logic [ADDR_W:0] level,
    input  logic            cts,
    output logic            send,
    output logic [7:0]      tx_byte
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [7:0]      rd_data;
    logic            push_ok;
    logic            pop;
    logic            send_nxt;
    txf_state_t      state;
    txf_state_t      state_nxt;

    // Extra pointer MSB distinguishes full from empty when the low bits match
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                   (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

    // Flush wins over both a push and a pop in the same cycle
    assign push_ok = wr_en && !full && !flush;
    assign pop     = (state == TXF_IDLE) && !empty && cts && !flush;

    plpbot_uart_fifo_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (rd_data)
    );

    always_ff @(negedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (flush) begin
                overflow <= 1'b0;
            end else if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state <= TXF_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TXF_IDLE: if (pop)  state_nxt = TXF_LOAD;
            TXF_LOAD:           state_nxt = TXF_BUSY;
            TXF_BUSY: if (!cts) state_nxt = TXF_DONE;
            TXF_DONE: if (cts)  state_nxt = TXF_IDLE;
            default:            state_nxt = TXF_IDLE;
        endcase
    end

    always_comb begin
        send_nxt = (state == TXF_LOAD);
    end

    // tx_byte is loaded a full cycle ahead of send and only changes on a pop
    always_ff @(negedge clk) begin
        if (rst) begin
            send    <= 1'b0;
            tx_byte <= 8'h00;
        end else begin
            send <= send_nxt;
            if (pop) begin
                tx_byte <= rd_data;
            end
        end
    end

`ifdef PLPBOT_UART_TXF_LEVEL_EN
    logic [ADDR_W:0] count;

    always_ff @(negedge clk) begin
        if (rst || flush) begin
            count <= '0;
        end else begin
            case ({push_ok, pop})
                2'b10:   count <= count + PTR_ONE;
                2'b01:   count <= count - PTR_ONE;
                default: count <= count;
            endcase
        end
    end

    assign level = count;
`else
    assign level = '0;
`endif

endmodule

// File: tb/tb_plpbot_uart_tx_fifo.sv
// Directed bench for plpbot_uart_tx_fifo (DEPTH=4) with a small behavioural stand-in for the UART core.
module tb_plpbot_uart_tx_fifo;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int CORE_BUSY_CYC = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en;
    logic [7:0]      wr_data;
    logic            flush;
    logic            full;
    logic            empty;
    logic            overflow;
    logic [ADDR_W:0] level;
    logic            cts;
    logic            send;
    logic [7:0]      tx_byte;

    logic            core_cts;
    logic            hold_cts;
    int              core_busy;
    logic [7:0]      cur_byte;
    int              stable_err;
    logic [7:0]      sent [$];

    int n_tests = 0;
    int n_fail  = 0;

    plpbot_uart_tx_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .flush    (flush),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .level    (level),
        .cts      (cts),
        .send     (send),
        .tx_byte  (tx_byte)
    );

    always #5 clk = ~clk;

    assign cts = core_cts && !hold_cts;

    // Core stand-in: on send, goes busy (cts low) for a fixed time and logs the byte
    always @(posedge clk) begin
        if (rst) begin
            core_busy = 0;
            core_cts  = 1'b1;
        end else begin
            if (core_busy > 0) begin
                if (tx_byte !== cur_byte) stable_err++;
                core_busy--;
                if (core_busy == 0) core_cts = 1'b1;
            end
            if (send) begin
                sent.push_back(tx_byte);
                cur_byte  = tx_byte;
                core_busy = CORE_BUSY_CYC;
                core_cts  = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        cyc();
        wr_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; hold_cts = 1'b0;
        core_cts = 1'b1; core_busy = 0; cur_byte = 8'h00; stable_err = 0;
        idle(3);
        chk("rst_send",     32'(send),     32'd0);
        chk("rst_tx_byte",  32'(tx_byte),  32'h00);
        chk("rst_empty",    32'(empty),    32'd1);
        chk("rst_full",     32'(full),     32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_level",    32'(level),    32'd0);
        rst = 1'b0;
        idle(2);

        // Single byte: pop one edge after the write, send one edge later for one cycle
        wr_en = 1'b1; wr_data = 8'h55;
        cyc();
        wr_en = 1'b0;
        chk("t1_empty_after_push", 32'(empty), 32'd0);
        chk("t1_send_n",           32'(send),  32'd0);
        cyc();
        chk("t1_tx_byte_pop", 32'(tx_byte), 32'h55);
        chk("t1_send_n1",     32'(send),    32'd0);
        chk("t1_empty_pop",   32'(empty),   32'd1);
        cyc();
        chk("t1_send_n2", 32'(send), 32'd1);
        cyc();
        chk("t1_send_n3", 32'(send), 32'd0);
        idle(15);
        chk("t1_count", 32'(sent.size()), 32'd1);
        if (sent.size() >= 1) chk("t1_byte", 32'(sent[0]), 32'h55);
        chk("t1_empty_end", 32'(empty), 32'd1);

        // Three back-to-back bytes drained in order, each after cts returns
        sent.delete();
        push(8'h01); push(8'h02); push(8'h03);
        idle(40);
        chk("t2_count", 32'(sent.size()), 32'd3);
        if (sent.size() == 3) begin
            chk("t2_b0", 32'(sent[0]), 32'h01);
            chk("t2_b1", 32'(sent[1]), 32'h02);
            chk("t2_b2", 32'(sent[2]), 32'h03);
        end
        chk("t2_stable", 32'(stable_err), 32'd0);

        // Overflow: cts held low, five writes into a four-entry FIFO
        sent.delete();
        hold_cts = 1'b1;
        push(8'hA1); push(8'hA2); push(8'hA3);
        chk("t3_full_3", 32'(full), 32'd0);
        push(8'hA4);
        chk("t3_full_4", 32'(full),     32'd1);
        chk("t3_ovf_4",  32'(overflow), 32'd0);
        push(8'hA5);
        chk("t3_full_5", 32'(full),     32'd1);
        chk("t3_ovf_5",  32'(overflow), 32'd1);
        chk("t3_no_send_held", 32'(sent.size()), 32'd0);
        hold_cts = 1'b0;
        idle(60);
        chk("t3_count", 32'(sent.size()), 32'd4);
        if (sent.size() == 4) begin
            chk("t3_first", 32'(sent[0]), 32'hA1);
            chk("t3_last",  32'(sent[3]), 32'hA4);
        end
        chk("t3_empty",    32'(empty),    32'd1);
        chk("t3_ovf_kept", 32'(overflow), 32'd1);

        // Flush while the first of three bytes is in flight
        sent.delete();
        push(8'hB1); push(8'hB2); push(8'hB3);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("t4_empty", 32'(empty),    32'd1);
        chk("t4_ovf",   32'(overflow), 32'd0);
        idle(30);
        chk("t4_count", 32'(sent.size()), 32'd1);
        if (sent.size() >= 1) chk("t4_byte", 32'(sent[0]), 32'hB1);

        // Reset while BUSY abandons the byte
        push(8'hC3);
        begin
            int k;
            for (k = 0; k < 10 && send !== 1'b1; k++) cyc();
            chk("t5_send_seen", 32'(send), 32'd1);
        end
        rst = 1'b1;
        cyc();
        chk("t5_send",    32'(send),    32'd0);
        chk("t5_tx_byte", 32'(tx_byte), 32'h00);
        chk("t5_empty",   32'(empty),   32'd1);
        rst = 1'b0;
        cyc();
        sent.delete();
        push(8'h3C);
        idle(20);
        chk("t5_count", 32'(sent.size()), 32'd1);
        if (sent.size() >= 1) chk("t5_byte", 32'(sent[0]), 32'h3C);

        // Occupancy: push three, then a pop with a concurrent push, then flush
        sent.delete();
        hold_cts = 1'b1;
        push(8'hD1); push(8'hD2); push(8'hD3);
        hold_cts = 1'b0;
        push(8'hD4);
`ifdef PLPBOT_UART_TXF_LEVEL_EN
        chk("t6_level_pushpop", 32'(level), 32'd3);
`else
        chk("t6_level_off",     32'(level), 32'd0);
`endif
        chk("t6_tx_byte", 32'(tx_byte), 32'hD1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("t6_level_flush", 32'(level), 32'd0);
        chk("t6_empty",       32'(empty), 32'd1);
        idle(25);
        chk("t6_count", 32'(sent.size()), 32'd1);
        chk("t6_stable", 32'(stable_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
